// File: rtl/commit_monitor.sv
// commit_monitor: retired-stream continuity, hang and alignment checker with counters and a PC trace FIFO.
module commit_monitor #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk_i,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                commit_i,
  input  logic [PC_WIDTH-1:0] commit_pc_i,
  input  logic [PC_WIDTH-1:0] commit_pre_pc_i,
  output logic                trace_valid_o,
  input  logic                trace_ready_i,
  output logic [PC_WIDTH-1:0] trace_pc_o,
  output logic [PC_WIDTH-1:0] trace_npc_o,
  output logic [31:0]         trace_seq_o,
  output logic [31:0]         retired_cnt_o,
  output logic [31:0]         cycle_cnt_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [PC_WIDTH-1:0] err_pc_o,
  output logic                overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT);
  localparam int EW = 2 * PC_WIDTH + 32;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t              state;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [PC_WIDTH-1:0] exp_pc, last_pc;
  logic [IW-1:0]       idle;
  logic                empty, full, pop, acc, push, mis, brk, hang;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && trace_ready_i;
  assign acc   = commit_i && state != HALT;
  assign push  = acc && (!full || pop);
  assign mis   = commit_pc_i[1:0] != 2'b00;
  assign brk   = state == RUN && commit_pc_i != exp_pc;
  assign hang  = state == RUN && !commit_i && idle == IW'(TIMEOUT - 1);
  assign trace_valid_o = !empty;
  assign {trace_pc_o, trace_npc_o, trace_seq_o} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i)
    if (rst && !clear_i && push) mem[wr_ptr[AW-1:0]] <= {commit_pc_i, commit_pre_pc_i, retired_cnt_o};
  always_ff @(posedge clk_i or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_pc        <= '0;
      last_pc       <= '0;
      idle          <= '0;
      retired_cnt_o <= '0;
      cycle_cnt_o   <= '0;
      err_o         <= 1'b0;
      err_code_o    <= 2'b00;
      err_pc_o      <= '0;
      overflow_o    <= 1'b0;
    end else if (clear_i) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_pc        <= '0;
      last_pc       <= '0;
      idle          <= '0;
      retired_cnt_o <= '0;
      cycle_cnt_o   <= '0;
      err_o         <= 1'b0;
      err_code_o    <= 2'b00;
      err_pc_o      <= '0;
      overflow_o    <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (acc && full && !pop) overflow_o <= 1'b1;
      if (state == RUN) cycle_cnt_o <= cycle_cnt_o + 1'b1;
      // the offending commit is still counted and traced before halting
      if (acc) begin
        retired_cnt_o <= retired_cnt_o + 1'b1;
        last_pc       <= commit_pc_i;
        exp_pc        <= commit_pre_pc_i;
        idle          <= '0;
        state         <= (mis || brk) ? HALT : RUN;
        if (mis || brk) begin
          err_o      <= 1'b1;
          err_code_o <= mis ? 2'b11 : 2'b01;
          err_pc_o   <= commit_pc_i;
        end
      end else if (hang) begin
        err_o      <= 1'b1;
        err_code_o <= 2'b10;
        err_pc_o   <= last_pc;
        state      <= HALT;
      end else if (state == RUN) idle <= idle + 1'b1;
    end
endmodule
